load_store_unit: RTL and testbench

//  Sits directly upstream of the write-back/write-allocate D-cache, between the execute stage and the cache core port.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_if.sv | 45 ++++
 rtl/lsu_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, error codes, FSM states.
package lsu_pkg;

    localparam logic [2:0] F3Byte      = 3'b000;
    localparam logic [2:0] F3Half      = 3'b001;
    localparam logic [2:0] F3Word      = 3'b010;
    localparam logic [2:0] F3ByteU     = 3'b100;
    localparam logic [2:0] F3HalfU     = 3'b101;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrMisalign = 2'b01,
        ErrIllegal  = 2'b10,
        ErrTimeout  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp,
        StFlush
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Bundle of execute-side request/response and cache-side port signals of the load/store unit.
interface lsu_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_store_i;
    logic [2:0]            req_funct3_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]           req_wdata_i;
    logic [4:0]            req_rd_i;
    logic                  flush_i;
    logic                  rsp_valid_o;
    logic [31:0]           rsp_rdata_o;
    logic [4:0]            rsp_rd_o;
    logic [1:0]            rsp_err_o;
    logic                  flush_done_o;
    logic [ADDR_WIDTH-1:0] cache_addr_o;
    logic [31:0]           cache_wdata_o;
    logic                  cache_write_o;
    logic [3:0]            cache_wstrb_o;
    logic                  cache_read_o;
    logic                  cache_cleanup_o;
    logic [31:0]           cache_rdata_i;
    logic                  cache_ready_i;

    // LSU view
    modport slave (
        input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  flush_i, cache_rdata_i, cache_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o, flush_done_o,
        output cache_addr_o, cache_wdata_o, cache_write_o, cache_wstrb_o, cache_read_o,
        output cache_cleanup_o
    );

    // Execute stage plus cache view
    modport master (
        output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output flush_i, cache_rdata_i, cache_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o, flush_done_o,
        input  cache_addr_o, cache_wdata_o, cache_write_o, cache_wstrb_o, cache_read_o,
        input  cache_cleanup_o
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, request legality checks,
// and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        st_store,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata_lanes,
    output lsu_err_e    chk_err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic        legal;
    logic        misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        legal = 1'b0;
        case (st_funct3)
            F3Byte, F3Half, F3Word: legal = 1'b1;
            F3ByteU, F3HalfU:       legal = !st_store;
            default:                legal = 1'b0;
        endcase
        misalign = ((st_funct3[1:0] == 2'b01) && st_addr[0]) ||
                   ((st_funct3[1:0] == 2'b10) && (st_addr != 2'b00));
        // Illegal encodings take priority over alignment.
        if (!legal) begin
            chk_err = ErrIllegal;
        end else if (misalign) begin
            chk_err = ErrMisalign;
        end else begin
            chk_err = ErrNone;
        end
    end

    always_comb begin
        st_wstrb       = 4'b1111;
        st_wdata_lanes = st_wdata;
        case (st_funct3[1:0])
            2'b00: begin
                st_wstrb       = 4'b0001 << st_addr;
                st_wdata_lanes = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                st_wstrb       = 4'b0011 << st_addr;
                st_wdata_lanes = {2{st_wdata[15:0]}};
            end
            default: begin
                st_wstrb       = 4'b1111;
                st_wdata_lanes = st_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[{ld_addr, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_addr[1], 4'b0000} +: 16];
        case (ld_funct3)
            F3Byte:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3ByteU: ld_data = {24'h000000, ld_byte};
            F3Half:  ld_data = {{16{ld_half[15]}}, ld_half};
            F3HalfU: ld_data = {16'h0000, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: registers each op, drives one word-aligned cache access until ready,
// returns extended load data, sequences cache cleanup and bounds both with a watchdog.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("load_store_unit supports DATA_WIDTH=32 only");
    end

    localparam int unsigned WdW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned WdLastInt = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [WdW-1:0] WdLast = WdW'(WdLastInt);

    lsu_state_e            state_q, state_d;
    logic [WdW-1:0]        wd_q, wd_d;
    logic                  store_q, store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [4:0]            rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [31:0]           cache_wdata_q, cache_wdata_d;
    logic [3:0]            cache_wstrb_q, cache_wstrb_d;
    logic                  cache_read_q, cache_read_d;
    logic                  cache_write_q, cache_write_d;
    logic                  cache_cleanup_q, cache_cleanup_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [4:0]            rsp_rd_q, rsp_rd_d;
    lsu_err_e              rsp_err_q, rsp_err_d;
    logic                  flush_done_q, flush_done_d;

    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata_lanes;
    lsu_err_e    chk_err;
    logic [31:0] ld_data;
    logic        timeout;

    lsu_align u_align (
        .st_store       (bus.req_store_i),
        .st_funct3      (bus.req_funct3_i),
        .st_addr        (bus.req_addr_i[1:0]),
        .st_wdata       (bus.req_wdata_i),
        .st_wstrb       (st_wstrb),
        .st_wdata_lanes (st_wdata_lanes),
        .chk_err        (chk_err),
        .ld_funct3      (funct3_q),
        .ld_addr        (addr_lo_q),
        .ld_rdata       (bus.cache_rdata_i),
        .ld_data        (ld_data)
    );

    assign timeout = (TIMEOUT_CYC != 0) && (wd_q == WdLast);

    always_comb begin
        state_d         = state_q;
        store_d         = store_q;
        funct3_d        = funct3_q;
        addr_lo_d       = addr_lo_q;
        rd_d            = rd_q;
        cache_addr_d    = cache_addr_q;
        cache_wdata_d   = cache_wdata_q;
        cache_wstrb_d   = cache_wstrb_q;
        cache_read_d    = cache_read_q;
        cache_write_d   = cache_write_q;
        cache_cleanup_d = cache_cleanup_q;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_rd_d        = rsp_rd_q;
        rsp_err_d       = rsp_err_q;
        flush_done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    store_d   = bus.req_store_i;
                    funct3_d  = bus.req_funct3_i;
                    addr_lo_d = bus.req_addr_i[1:0];
                    rd_d      = bus.req_rd_i;
                    if (chk_err != ErrNone) begin
                        // Rejected ops never reach the cache.
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_rd_d    = bus.req_rd_i;
                        rsp_err_d   = chk_err;
                    end else begin
                        state_d       = StAccess;
                        cache_addr_d  = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        cache_wdata_d = bus.req_store_i ? st_wdata_lanes : '0;
                        cache_wstrb_d = bus.req_store_i ? st_wstrb : 4'b0000;
                        cache_read_d  = !bus.req_store_i;
                        cache_write_d = bus.req_store_i;
                    end
                end else if (bus.flush_i) begin
                    state_d         = StFlush;
                    cache_cleanup_d = 1'b1;
                end
            end
            StAccess: begin
                if (bus.cache_ready_i || timeout) begin
                    state_d       = StResp;
                    cache_read_d  = 1'b0;
                    cache_write_d = 1'b0;
                    cache_wstrb_d = 4'b0000;
                    rsp_valid_d   = 1'b1;
                    rsp_rd_d      = rd_q;
                    if (bus.cache_ready_i) begin
                        rsp_rdata_d = store_q ? '0 : ld_data;
                        rsp_err_d   = ErrNone;
                    end else begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = ErrTimeout;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            StFlush: begin
                if (bus.cache_ready_i || timeout) begin
                    state_d         = StIdle;
                    cache_cleanup_d = 1'b0;
                    flush_done_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog restarts on every state entry and only runs while waiting on the cache.
        if ((state_d != state_q) || (state_q == StIdle) || (state_q == StResp)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            wd_q            <= '0;
            store_q         <= 1'b0;
            funct3_q        <= '0;
            addr_lo_q       <= '0;
            rd_q            <= '0;
            cache_addr_q    <= '0;
            cache_wdata_q   <= '0;
            cache_wstrb_q   <= '0;
            cache_read_q    <= 1'b0;
            cache_write_q   <= 1'b0;
            cache_cleanup_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_rd_q        <= '0;
            rsp_err_q       <= ErrNone;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            wd_q            <= wd_d;
            store_q         <= store_d;
            funct3_q        <= funct3_d;
            addr_lo_q       <= addr_lo_d;
            rd_q            <= rd_d;
            cache_addr_q    <= cache_addr_d;
            cache_wdata_q   <= cache_wdata_d;
            cache_wstrb_q   <= cache_wstrb_d;
            cache_read_q    <= cache_read_d;
            cache_write_q   <= cache_write_d;
            cache_cleanup_q <= cache_cleanup_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_rd_q        <= rsp_rd_d;
            rsp_err_q       <= rsp_err_d;
            flush_done_q    <= flush_done_d;
        end
    end

    assign bus.req_ready_o     = (state_q == StIdle);
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_rdata_o     = rsp_rdata_q;
    assign bus.rsp_rd_o        = rsp_rd_q;
    assign bus.rsp_err_o       = rsp_err_q;
    assign bus.flush_done_o    = flush_done_q;
    assign bus.cache_addr_o    = cache_addr_q;
    assign bus.cache_wdata_o   = cache_wdata_q;
    assign bus.cache_wstrb_o   = cache_wstrb_q;
    assign bus.cache_read_o    = cache_read_q;
    assign bus.cache_write_o   = cache_write_q;
    assign bus.cache_cleanup_o = cache_cleanup_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: one LSU with the default watchdog for access paths, one with an
// 8-cycle watchdog for timeout and cleanup sequencing.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_if #(.ADDR_WIDTH(32)) bus ();
    lsu_if #(.ADDR_WIDTH(32)) bus2 ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(8)) dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor for the main DUT; lat of 0 means latency is not checked.
    always @(negedge clk) begin
        if (bus.rsp_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("stray_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rd", 32'(bus.rsp_rd_o), 32'(e.rd));
                chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                chk("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
                if (e.lat != 0) chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] erdata, input logic [1:0] eerr, input int elat);
        int n;
        exp_t e;
        n = 0;
        while (bus.req_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_store_i  = st;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_rd_i     = rd;
        e.rd = rd; e.rdata = erdata; e.err = eerr; e.lat = elat; e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // Called in the first ACCESS cycle; holds ready low for 'waits' cycles then completes.
    task automatic serve(input int waits, input logic [31:0] rdata, input logic [31:0] eaddr,
                         input logic ewr, input logic [3:0] estrb, input logic [31:0] ewdata);
        for (int i = 0; i <= waits; i++) begin
            chk("cache_addr", bus.cache_addr_o, eaddr);
            chk("cache_rw", {30'd0, bus.cache_write_o, bus.cache_read_o}, ewr ? 32'd2 : 32'd1);
            chk("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
            if (ewr) begin
                chk("cache_wstrb", 32'(bus.cache_wstrb_o), 32'(estrb));
                chk("cache_wdata", bus.cache_wdata_o, ewdata);
            end
            if (i == waits) begin
                bus.cache_ready_i = 1'b1;
                bus.cache_rdata_i = rdata;
            end
            @(negedge clk);
        end
        bus.cache_ready_i = 1'b0;
        bus.cache_rdata_i = 32'd0;
    endtask

    task automatic drain();
        for (int n = 0; n < 5 && sb.size() != 0; n++) @(negedge clk);
        chk("rsp_outstanding", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        bus.req_valid_i = 0; bus.req_store_i = 0; bus.req_funct3_i = 0; bus.req_addr_i = 0;
        bus.req_wdata_i = 0; bus.req_rd_i = 0; bus.flush_i = 0; bus.cache_rdata_i = 0;
        bus.cache_ready_i = 0;
        bus2.req_valid_i = 0; bus2.req_store_i = 0; bus2.req_funct3_i = 0; bus2.req_addr_i = 0;
        bus2.req_wdata_i = 0; bus2.req_rd_i = 0; bus2.flush_i = 0; bus2.cache_rdata_i = 0;
        bus2.cache_ready_i = 0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_cache_ctl", {29'd0, bus.cache_read_o, bus.cache_write_o, bus.cache_cleanup_o}, 0);
        chk("rst_cache_addr", bus.cache_addr_o, 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done_o), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB hit: lane 3, replicated byte, response two cycles after accept
        issue(1'b1, 3'b000, 32'h103, 32'hA5, 5'd3, 32'd0, 2'b00, 2);
        serve(0, 32'd0, 32'h100, 1'b1, 4'b1000, 32'hA5A5A5A5);
        drain();

        // LB / LBU from lane 2 with a few wait cycles
        issue(1'b0, 3'b000, 32'h202, 32'd0, 5'd4, 32'hFFFFFF80, 2'b00, 6);
        serve(4, 32'h0080FF00, 32'h200, 1'b0, 4'b0000, 32'd0);
        drain();
        issue(1'b0, 3'b100, 32'h202, 32'd0, 5'd5, 32'h00000080, 2'b00, 6);
        serve(4, 32'h0080FF00, 32'h200, 1'b0, 4'b0000, 32'd0);
        drain();

        // Misaligned LH and illegal funct3 never touch the cache
        issue(1'b0, 3'b001, 32'h301, 32'd0, 5'd6, 32'd0, 2'b01, 1);
        chk("err_no_cache", {30'd0, bus.cache_read_o, bus.cache_write_o}, 32'd0);
        @(negedge clk);
        chk("err_no_cache2", {30'd0, bus.cache_read_o, bus.cache_write_o}, 32'd0);
        issue(1'b0, 3'b011, 32'h300, 32'd0, 5'd7, 32'd0, 2'b10, 1);
        chk("ill_no_cache", {30'd0, bus.cache_read_o, bus.cache_write_o}, 32'd0);
        issue(1'b1, 3'b100, 32'h300, 32'd0, 5'd8, 32'd0, 2'b10, 1);
        issue(1'b1, 3'b010, 32'h302, 32'd0, 5'd9, 32'd0, 2'b01, 1);
        drain();

        // SH miss: ready low 10 cycles, everything stable, single response
        issue(1'b1, 3'b001, 32'h302, 32'h1234BEEF, 5'd10, 32'd0, 2'b00, 12);
        serve(10, 32'd0, 32'h300, 1'b1, 4'b1100, 32'hBEEFBEEF);
        drain();

        // Halfword and word loads
        issue(1'b0, 3'b101, 32'h302, 32'd0, 5'd11, 32'h00008001, 2'b00, 3);
        serve(1, 32'h80010000, 32'h300, 1'b0, 4'b0000, 32'd0);
        drain();
        issue(1'b0, 3'b001, 32'h302, 32'd0, 5'd12, 32'hFFFF8001, 2'b00, 2);
        serve(0, 32'h80010000, 32'h300, 1'b0, 4'b0000, 32'd0);
        drain();

        // Request and flush together: request wins
        bus.flush_i = 1'b1;
        issue(1'b0, 3'b010, 32'h400, 32'd0, 5'd13, 32'hDEADBEEF, 2'b00, 2);
        chk("req_beats_flush", 32'(bus.cache_cleanup_o), 32'd0);
        bus.flush_i = 1'b0;
        serve(0, 32'hDEADBEEF, 32'h400, 1'b0, 4'b0000, 32'd0);
        drain();

        // Reset mid-ACCESS drops the op
        issue(1'b0, 3'b010, 32'h500, 32'd0, 5'd14, 32'd0, 2'b00, 0);
        chk("pre_rst_read", 32'(bus.cache_read_o), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_ctl", {29'd0, bus.cache_read_o, bus.cache_write_o, bus.cache_cleanup_o}, 0);
        chk("mid_rst_addr", bus.cache_addr_o, 32'd0);
        chk("mid_rst_rsp", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("post_rst_read", 32'(bus.cache_read_o), 32'd0);

        // Watchdog: load never served
        bus2.req_valid_i = 1'b1; bus2.req_funct3_i = 3'b010; bus2.req_addr_i = 32'h600;
        bus2.req_rd_i = 5'd9;
        @(negedge clk);
        bus2.req_valid_i = 1'b0;
        n = 0;
        while (bus2.cache_read_o === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_read_cycles", 32'(n), 32'd8);
        chk("to_rsp_valid", 32'(bus2.rsp_valid_o), 32'd1);
        chk("to_rsp_err", 32'(bus2.rsp_err_o), 32'd3);
        chk("to_rsp_rdata", bus2.rsp_rdata_o, 32'd0);
        chk("to_rsp_rd", 32'(bus2.rsp_rd_o), 32'd9);
        @(negedge clk);
        chk("to_rsp_once", 32'(bus2.rsp_valid_o), 32'd0);
        chk("to_ready_back", 32'(bus2.req_ready_o), 32'd1);

        // Cleanup held until ready
        bus2.flush_i = 1'b1;
        @(negedge clk);
        chk("fl_busy", 32'(bus2.req_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("fl_cleanup_held", 32'(bus2.cache_cleanup_o), 32'd1);
            chk("fl_done_early", 32'(bus2.flush_done_o), 32'd0);
            @(negedge clk);
        end
        bus2.cache_ready_i = 1'b1;
        @(negedge clk);
        bus2.cache_ready_i = 1'b0;
        bus2.flush_i = 1'b0;
        chk("fl_cleanup_drop", 32'(bus2.cache_cleanup_o), 32'd0);
        chk("fl_done_pulse", 32'(bus2.flush_done_o), 32'd1);
        @(negedge clk);
        chk("fl_done_once", 32'(bus2.flush_done_o), 32'd0);
        chk("fl_idle", 32'(bus2.req_ready_o), 32'd1);

        // Cleanup never acknowledged: watchdog ends it
        bus2.flush_i = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus2.cache_cleanup_o === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        bus2.flush_i = 1'b0;
        chk("fl_to_cycles", 32'(n), 32'd8);
        chk("fl_to_done", 32'(bus2.flush_done_o), 32'd1);
        @(negedge clk);
        chk("fl_to_done_once", 32'(bus2.flush_done_o), 32'd0);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
